// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side drain engine and the write-side
// feeder, which uses the same credit scheme.
//   OUTBUF_DEPTH : entries in the output buffer (credit limit)
//   OCC_W/occ_t  : width/type able to hold 0..OUTBUF_DEPTH
//   credit_ok()  : true when one more pop fits in buffer plus in-flight slot
package fifo_rd_stream_pkg;

    localparam int unsigned OUTBUF_DEPTH = 2;
    localparam int unsigned OCC_W        = $clog2(OUTBUF_DEPTH + 1);

    typedef logic [OCC_W-1:0] occ_t;

    // Words that will occupy the buffer after this edge, counting the pop
    // outstanding from last cycle and the slot freed by this cycle's handshake.
    function automatic logic credit_ok(input occ_t occ, input logic pending,
                                       input logic pop);
        logic [OCC_W:0] w_inflight;
        w_inflight = {1'b0, occ} + {{OCC_W{1'b0}}, pending}
                   - {{OCC_W{1'b0}}, pop};
        return w_inflight < (OCC_W + 1)'(OUTBUF_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry output buffer for fifo_rd_stream.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push         : capture i_push_data this edge
//   i_push_data    : word returned by the FIFO
//   i_pop          : downstream handshake completes this edge
//   o_valid        : buffer non-empty (registered)
//   o_data         : oldest buffered word (registered)
//   o_occ          : number of filled entries, 0..2
module fifo_rd_skid2
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned data_width = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [data_width-1:0] i_push_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [data_width-1:0] o_data,
    output occ_t                  o_occ
);

    logic [data_width-1:0] r_buf [OUTBUF_DEPTH];
    logic                  r_wr_idx;
    logic                  r_rd_idx;
    occ_t                  r_occ;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < OUTBUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_buf[r_wr_idx] <= i_push_data;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (i_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_occ <= r_occ + occ_t'(i_push) - occ_t'(i_pop);
        end
    end

    always_comb begin
        o_valid = (r_occ != '0);
        o_data  = r_buf[r_rd_idx];
        o_occ   = r_occ;
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for the CDC FIFO: pops whenever the FIFO is
// non-empty and buffer credit exists, absorbs the one-cycle read latency and
// presents words on a valid/ready stream. Counts delivered words.
//   rd_clk, rd_rst_n : read clock, async active-low reset
//   en               : drain enable (gates new pops only)
//   fifo_empty       : FIFO empty flag
//   fifo_rd          : pop request (combinational)
//   fifo_rd_data     : FIFO data, valid the cycle after a pop
//   out_valid/ready  : output stream handshake
//   out_data         : output stream word
//   word_cnt         : completed handshakes, wrapping
//   busy             : pop in flight or buffer non-empty
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned cnt_width  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [data_width-1:0] fifo_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic [cnt_width-1:0]  word_cnt,
    output logic                  busy
);

    localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);

    logic                 r_pending;
    logic [cnt_width-1:0] r_word_cnt;
    logic                 w_pop;
    occ_t                 w_occ;

    fifo_rd_skid2 #(
        .data_width(data_width)
    ) u_skid (
        .i_clk      (rd_clk),
        .i_rst_n    (rd_rst_n),
        .i_push     (r_pending),
        .i_push_data(fifo_rd_data),
        .i_pop      (w_pop),
        .o_valid    (out_valid),
        .o_data     (out_data),
        .o_occ      (w_occ)
    );

    // Reset gates fifo_rd so the FIFO is never popped while state is cleared.
    always_comb begin
        w_pop   = out_valid & out_ready;
        fifo_rd = rd_rst_n & en & ~fifo_empty
                & credit_ok(w_occ, r_pending, w_pop);
        busy    = r_pending | out_valid;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_pending  <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_pending <= fifo_rd;
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + CNT_ONE;
            end
        end
    end

    assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default widths
    logic        a_rst_n, a_en, a_empty, a_rd, a_valid, a_ready, a_busy;
    logic [7:0]  a_rd_data, a_data;
    logic [15:0] a_cnt;
    // DUT B: 4-bit counter for wrap check
    logic        b_rst_n, b_en, b_empty, b_rd, b_valid, b_ready, b_busy;
    logic [7:0]  b_rd_data, b_data;
    logic [3:0]  b_cnt;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];

    int n_vec  = 0;
    int n_miss = 0;

    fifo_rd_stream dut (
        .rd_clk(clk), .rd_rst_n(a_rst_n), .en(a_en), .fifo_empty(a_empty),
        .fifo_rd(a_rd), .fifo_rd_data(a_rd_data), .out_valid(a_valid),
        .out_ready(a_ready), .out_data(a_data), .word_cnt(a_cnt), .busy(a_busy)
    );

    fifo_rd_stream #(.data_width(8), .cnt_width(4)) dut_b (
        .rd_clk(clk), .rd_rst_n(b_rst_n), .en(b_en), .fifo_empty(b_empty),
        .fifo_rd(b_rd), .fifo_rd_data(b_rd_data), .out_valid(b_valid),
        .out_ready(b_ready), .out_data(b_data), .word_cnt(b_cnt), .busy(b_busy)
    );

    // FIFO read-side models: one-cycle registered read latency, data held otherwise.
    always @(posedge clk) begin
        if (a_rd) begin
            a_rd_data <= qa.pop_front();
        end
        a_empty <= (qa.size() == 0);
    end

    always @(posedge clk) begin
        if (b_rd) begin
            b_rd_data <= qb.pop_front();
        end
        b_empty <= (qb.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        qa.push_back(d);
        a_empty = 1'b0;
    endtask

    int         n_rd;
    int         e;
    int         got_n;
    logic [7:0] got_w[$];
    logic [7:0] rexp[$];

    initial begin
        a_rst_n = 1'b0; a_en = 1'b1; a_ready = 1'b1; a_empty = 1'b1; a_rd_data = '0;
        b_rst_n = 1'b0; b_en = 1'b0; b_ready = 1'b1; b_empty = 1'b1; b_rd_data = '0;

        // ---- reset with FIFO non-empty ----
        @(negedge clk);
        for (int i = 1; i <= 8; i++) push_a(8'(i));
        repeat (3) @(negedge clk);
        #1;
        chk("rst_fifo_rd", a_rd, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_data", a_data, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_busy", a_busy, 0);

        // ---- release -> streaming 0x01..0x08 ----
        @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        #1;
        chk("rel_fifo_rd", a_rd, 1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk); #1;
            if (k == 1) begin
                chk("str_lat_valid", a_valid, 0);
            end else begin
                chk("str_valid", a_valid, 1);
                chk("str_data", a_data, 32'(k - 1));
            end
        end
        @(negedge clk); #1;
        chk("str_end_valid", a_valid, 0);
        chk("str_end_cnt", a_cnt, 8);
        chk("str_end_busy", a_busy, 0);

        // ---- backpressure: 5 words, out_ready low ----
        @(negedge clk);
        a_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_a(8'(i));
        #1;
        n_rd = int'(a_rd);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); #1;
            n_rd += int'(a_rd);
        end
        chk("bp_pulses", 32'(n_rd), 2);
        chk("bp_fifo_rd_low", a_rd, 0);
        chk("bp_valid", a_valid, 1);
        chk("bp_hold_data", a_data, 8'h01);
        @(negedge clk);
        a_ready = 1'b1;
        #1;
        chk("bp_free_same_cycle", a_rd, 1);
        chk("bp_w1", a_data, 8'h01);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk); #1;
            chk("bp_no_gap", a_valid, 1);
            chk("bp_word", a_data, 32'(k));
        end
        @(negedge clk); #1;
        chk("bp_end_valid", a_valid, 0);
        chk("bp_end_cnt", a_cnt, 13);
        chk("bp_end_busy", a_busy, 0);

        // ---- random out_ready over 1000 words ----
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            rexp.push_back(8'((i * 37 + 5) & 8'hff));
            push_a(8'((i * 37 + 5) & 8'hff));
        end
        e = 0;
        for (int cyc = 0; cyc < 6000 && e < 1000; cyc++) begin
            @(negedge clk);
            a_ready = 1'($urandom_range(1, 0));
            #1;
            if (dut.w_occ > 2) chk("rnd_occ_le2", 32'(dut.w_occ), 2);
            if (a_valid && a_ready) begin
                chk("rnd_data", a_data, rexp[e]);
                e++;
            end
        end
        chk("rnd_all_words", 32'(e), 1000);
        @(negedge clk);
        a_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rnd_no_dup", a_valid, 0);
        chk("rnd_cnt", a_cnt, 1013);

        // ---- en dropped the cycle fifo_rd rises ----
        @(negedge clk);
        push_a(8'hA1); push_a(8'hA2); push_a(8'hA3);
        #1;
        chk("en_first_rd", a_rd, 1);
        @(negedge clk);
        a_en = 1'b0;
        #1;
        chk("en_low_rd", a_rd, 0);
        n_rd = 0;
        got_w.delete();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_rd += int'(a_rd);
            if (a_valid && a_ready) got_w.push_back(a_data);
        end
        chk("en_no_pops", 32'(n_rd), 0);
        got_n = got_w.size();
        chk("en_inflight_cnt", 32'(got_n), 1);
        if (got_n > 0) chk("en_inflight_word", got_w[0], 8'hA1);
        @(negedge clk);
        a_en = 1'b1;
        #1;
        chk("en_resume_rd", a_rd, 1);
        got_w.delete();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            if (a_valid && a_ready) got_w.push_back(a_data);
        end
        got_n = got_w.size();
        chk("en_resume_cnt", 32'(got_n), 2);
        if (got_n > 1) begin
            chk("en_resume_w0", got_w[0], 8'hA2);
            chk("en_resume_w1", got_w[1], 8'hA3);
        end
        chk("en_word_cnt", a_cnt, 1016);

        // ---- 4-bit counter wrap on DUT B ----
        @(negedge clk);
        for (int i = 0; i < 17; i++) qb.push_back(8'(i));
        b_empty = 1'b0;
        b_en = 1'b1;
        repeat (25) @(negedge clk);
        #1;
        chk("wrap_cnt", b_cnt, 1);
        chk("wrap_busy", b_busy, 0);

        // ---- asynchronous reset mid-stream ----
        @(negedge clk);
        a_ready = 1'b0;
        push_a(8'h5A); push_a(8'h5B); push_a(8'h5C); push_a(8'h5D);
        repeat (4) @(negedge clk);
        #1;
        chk("mid_valid_pre", a_valid, 1);
        chk("mid_data_pre", a_data, 8'h5A);
        #1;
        a_rst_n = 1'b0;
        #1;
        chk("mid_async_valid", a_valid, 0);
        chk("mid_async_data", a_data, 0);
        chk("mid_async_cnt", a_cnt, 0);
        chk("mid_async_busy", a_busy, 0);
        chk("mid_async_rd", a_rd, 0);
        qa.delete();
        a_empty = 1'b1;
        @(negedge clk);
        a_rst_n = 1'b1;
        @(negedge clk); #1;
        chk("mid_after_valid", a_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the team's clock-domain-crossing FIFO. It sits in the read clock domain and issues pops whenever the FIFO is non-empty and space is available. It absorbs the FIFO's one-cycle registered read latency and presents the words on a valid/ready stream with a 2-entry output buffer, so downstream backpressure never drops or duplicates data. It also counts delivered words.

## Interface
- data_width, 8, word width; must match the FIFO's data width.
- cnt_width, 16, width of the delivered-word counter.

Ports (clock and reset first):
- rd_clk  in  1  read-domain clock; same clock as the FIFO read side.
- rd_rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  drain enable; when low, no new pops are issued.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  pop request to the FIFO.
- fifo_rd_data  in  data_width  FIFO read data; valid the cycle after a pop is accepted, held otherwise.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  data_width  stream word.
- word_cnt  out  cnt_width  count of completed out handshakes; wraps.
- busy  out  1  high when a pop is pending or the buffer is non-empty.

## Operation
- State:
  - pending: 1-bit, a pop was issued last cycle.
  - buf[0:1]: 2 entries of data_width.
  - wr_idx, rd_idx: 1-bit indices into buf.
  - occ: 0..2, number of filled buf entries.
- pop = out_valid & out_ready.
- fifo_rd is combinational from registered state plus inputs: fifo_rd = en & ~fifo_empty & ((occ + pending - pop) < 2).
  - fifo_rd is never asserted while fifo_empty is high, so every asserted fifo_rd is a real pop.
- Each edge:
  - pending <= fifo_rd.
  - If pending: buf[wr_idx] <= fifo_rd_data, and wr_idx toggles.
  - If pop: rd_idx toggles and word_cnt increments by 1, wrapping modulo 2^cnt_width.
  - occ <= occ + pending - pop.
- out_valid = (occ != 0). out_data = buf[rd_idx]. Both are driven from registers only.
- Simultaneous capture and pop with occ=2 cannot occur, because the credit rule prevents it. The bench asserts occ never exceeds 2.
- en deasserted mid-stream: the in-flight pop still completes and buffered words still drain. No words are lost.
- busy = pending | (occ != 0).
- Reset values: fifo_rd=0 (fifo_empty is ignored while in reset), out_valid=0, out_data=0, word_cnt=0, busy=0, pending=0, occ=0, indices=0.
- Reset mid-operation clears all state immediately, including buffered words. rd_rst_n must be asserted together with the FIFO read-side reset, otherwise one word may be lost.

## Timing
- Pop-to-valid latency: fifo_rd high in cycle n gives out_valid high in cycle n+2 (capture happens at the end of cycle n+1).
- Sustained throughput is 1 word/cycle with out_ready held high and the FIFO non-empty.
- With out_ready low, at most 2 pops are outstanding (buffer plus pending). fifo_rd stays low until a pop frees a slot.
  - Freeing occurs in the same cycle as out_ready rises, because fifo_rd uses the current-cycle pop term.
- out_data is stable while out_valid=1 and out_ready=0.
- out_valid does not depend combinationally on out_ready.
- word_cnt updates on the edge that completes the handshake.
- Only combinational path: en, fifo_empty, out_ready -> fifo_rd.

## Structure
- Shared package/include: constant OUTBUF_DEPTH=2 and the occ width derived from it. These are shared with the write-side feeder, which uses the same credit scheme.
- One natural sub-module: fifo_rd_skid2, holding the 2-entry buffer with its indices and occ. The top keeps pending, the credit logic, word_cnt and busy.
- Single-clock design; no synchronizers inside. Gray-pointer crossing remains in the FIFO.

## Test plan
- Reset: hold rd_rst_n=0 with fifo_empty=0 and en=1 -> fifo_rd=0, out_valid=0, word_cnt=0. Release -> fifo_rd=1 in the first cycle.
- Streaming:
  - Stimulus: FIFO preloaded with 0x01..0x08, out_ready=1, en=1.
  - out_valid rises 2 cycles after the first fifo_rd.
  - out_data is 0x01..0x08 on 8 consecutive cycles.
  - word_cnt=8, busy=0 at the end.
- Backpressure:
  - Stimulus: 5 words queued, out_ready=0.
  - Exactly 2 fifo_rd pulses occur, then fifo_rd stays 0 and out_data holds 0x01.
  - Raising out_ready gives all 5 words in order with no gaps after the first.
- Random out_ready toggling (50%) over 1000 words -> in-order data, no loss, no duplicates, occ<=2, word_cnt=1000.
- en dropped the same cycle as fifo_rd -> that word is still delivered and no further pops occur. Re-raising en resumes with the next word.
- Wrap: cnt_width=4 with 17 words -> word_cnt reads 1. Mid-stream rd_rst_n pulse -> outputs return to reset values asynchronously, before the next edge.
